game_seq_ctrl: RTL and testbench



---
 rtl/game_seq_ctrl_pkg.sv | 48 ++++
 rtl/game_seq_ctrl_tick_gen.sv | 47 ++++
 rtl/game_seq_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_game_seq_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/game_seq_ctrl_pkg.sv
// Shared definitions for the two-player factorization game sequencer:
// state codes, score limit, answer lookup and LFSR step.
package game_seq_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'b0000,
      ST_READY    = 4'b0010,
      ST_QUESTION = 4'b0011,
      ST_INPUT    = 4'b0100,
      ST_DRAW     = 4'b0110,
      ST_WRONG    = 4'b0111,
      ST_GOOD     = 4'b1000,
      ST_OUCH     = 4'b1001,
      ST_WIN      = 4'b1010,
      ST_LOSE     = 4'b1011
   } state_t;

   localparam logic [3:0] SCORE_MAX = 4'd9;
   localparam logic [3:0] DIN_MAX   = 4'd9;

   // Smallest prime factor of a question digit 2..9.
   function automatic logic [3:0] spf(input logic [3:0] q);
      logic [3:0] r;
      case (q)
         4'd2:    r = 4'd2;
         4'd3:    r = 4'd3;
         4'd4:    r = 4'd2;
         4'd5:    r = 4'd5;
         4'd6:    r = 4'd2;
         4'd7:    r = 4'd7;
         4'd8:    r = 4'd2;
         4'd9:    r = 4'd3;
         default: r = 4'd2;
      endcase
      return r;
   endfunction

   // Score increment that sticks at the match-winning limit.
   function automatic logic [3:0] sat_inc(input logic [3:0] s);
      return (s >= SCORE_MAX) ? SCORE_MAX : (s + 4'd1);
   endfunction

   // One step of the x^8+x^6+x^5+x^4+1 Fibonacci LFSR (shift left).
   function automatic logic [7:0] lfsr_next(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

endpackage

// File: rtl/game_seq_ctrl_tick_gen.sv
// Timer for the game sequencer: a prescaler producing a tick every TICK_DIV
// cycles and a tick counter. Both restart on clr so a duration counts from
// the cycle after clr.
module game_seq_ctrl_tick_gen #(
   parameter int TICK_DIV = 500000,
   parameter int CW       = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   output logic          tick,
   output logic [CW-1:0] tick_cnt
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [PW-1:0] presc_r;
   logic [CW-1:0] cnt_r;

   assign tick     = (presc_r == PW'(TICK_DIV - 1));
   assign tick_cnt = cnt_r;

   // Prescaler: wraps at TICK_DIV-1, realigned on clr.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_r <= '0;
      end else if (clr || tick) begin
         presc_r <= '0;
      end else begin
         presc_r <= presc_r + PW'(1);
      end
   end

   // Tick counter: counts ticks since the last clr.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (clr) begin
         cnt_r <= '0;
      end else if (tick) begin
         cnt_r <= cnt_r + CW'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/game_seq_ctrl.sv
// Two-player round sequencer for the factorization game.
// Optional build macro FALSE_START_EN: entries during QUESTION are judged as
// wrong answers for the entering player(s).
module game_seq_ctrl
   import game_seq_ctrl_pkg::*;
#(
   parameter int         TICK_DIV       = 500000,
   parameter int         READY_TICKS    = 100,
   parameter int         QUESTION_TICKS = 50,
   parameter int         INPUT_STEP     = 30,
   parameter int         RESULT_TICKS   = 150,
   parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic       P1_ENT,
   input  logic [3:0] P1_DIN,
   input  logic       P2_ENT,
   input  logic [3:0] P2_DIN,
   output logic [3:0] STATE,
   output logic [3:0] QUE,
   output logic [3:0] DIN,
   output logic [3:0] P1_SCORE,
   output logic [3:0] P2_SCORE
);

   state_t      state_r, state_nx;
   logic [3:0]  que_r, que_nx, din_r, din_nx;
   logic [3:0]  p1_r, p1_nx, p2_r, p2_nx;
   logic [7:0]  lfsr_r;
   logic        tick_s, elapsed_s, clr_s, fs_window_s, judge_en_s;
   logic        p1_ok_s, p2_ok_s, jvalid_s, p1_pt_s, p2_pt_s;
   logic [15:0] tick_cnt_s, limit_s;
   state_t      jstate_s;

   assign STATE    = state_r;
   assign QUE      = que_r;
   assign DIN      = din_r;
   assign P1_SCORE = p1_r;
   assign P2_SCORE = p2_r;

   game_seq_ctrl_tick_gen #(.TICK_DIV(TICK_DIV), .CW(16)) u_tick (
      .clk      (CLK),
      .rst      (RST),
      .clr      (clr_s),
      .tick     (tick_s),
      .tick_cnt (tick_cnt_s)
   );

`ifdef FALSE_START_EN
   assign fs_window_s = (state_r == ST_QUESTION);
`else
   assign fs_window_s = 1'b0;
`endif

   // Answers only count as correct during INPUT; a false start is always wrong.
   assign judge_en_s = (state_r == ST_INPUT) || fs_window_s;
   assign p1_ok_s    = (state_r == ST_INPUT) && (P1_DIN == spf(que_r));
   assign p2_ok_s    = (state_r == ST_INPUT) && (P2_DIN == spf(que_r));
   assign elapsed_s  = tick_s && (tick_cnt_s == (limit_s - 16'd1)) && (state_r != ST_IDLE);
   assign clr_s      = (state_nx != state_r) || elapsed_s;

   // Duration of the current state (or of one DIN step) in ticks.
   always_comb begin
      limit_s = 16'd1;
      case (state_r)
         ST_READY:    limit_s = 16'(READY_TICKS);
         ST_QUESTION: limit_s = 16'(QUESTION_TICKS);
         ST_INPUT:    limit_s = 16'(INPUT_STEP);
         ST_DRAW, ST_WRONG, ST_GOOD, ST_OUCH, ST_WIN, ST_LOSE:
                      limit_s = 16'(RESULT_TICKS);
         default:     limit_s = 16'd1;
      endcase
   end

   // Judge this cycle's entries: outcome state and who scores.
   always_comb begin
      jvalid_s = 1'b0;
      jstate_s = ST_DRAW;
      p1_pt_s  = 1'b0;
      p2_pt_s  = 1'b0;
      if (judge_en_s && (P1_ENT || P2_ENT)) begin
         jvalid_s = 1'b1;
         if (P1_ENT && P2_ENT) begin
            if (p1_ok_s && p2_ok_s) begin
               jstate_s = ST_GOOD;
            end else if (p1_ok_s) begin
               jstate_s = ST_WIN;
               p1_pt_s  = 1'b1;
            end else if (p2_ok_s) begin
               jstate_s = ST_LOSE;
               p2_pt_s  = 1'b1;
            end else begin
               jstate_s = ST_DRAW;
            end
         end else if (P1_ENT) begin
            if (p1_ok_s) begin
               jstate_s = ST_WIN;
               p1_pt_s  = 1'b1;
            end else begin
               jstate_s = ST_WRONG;
               p2_pt_s  = 1'b1;
            end
         end else begin
            if (p2_ok_s) begin
               jstate_s = ST_LOSE;
               p2_pt_s  = 1'b1;
            end else begin
               jstate_s = ST_OUCH;
               p1_pt_s  = 1'b1;
            end
         end
      end else begin
         jvalid_s = 1'b0;
      end
   end

   // Next state, question latch, DIN progress and scoring.
   always_comb begin
      state_nx = state_r;
      que_nx   = que_r;
      din_nx   = din_r;
      p1_nx    = p1_r;
      p2_nx    = p2_r;
      case (state_r)
         ST_IDLE: begin
            if (START) begin
               state_nx = ST_READY;
               if ((p1_r == SCORE_MAX) || (p2_r == SCORE_MAX)) begin
                  p1_nx = 4'd0;
                  p2_nx = 4'd0;
               end else begin
                  p1_nx = p1_r;
                  p2_nx = p2_r;
               end
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_READY: begin
            if (elapsed_s) begin
               state_nx = ST_QUESTION;
               que_nx   = 4'd2 + {1'b0, lfsr_r[2:0]};
            end else begin
               state_nx = ST_READY;
            end
         end
         ST_QUESTION, ST_INPUT: begin
            if (jvalid_s) begin
               state_nx = jstate_s;
               p1_nx    = p1_pt_s ? sat_inc(p1_r) : p1_r;
               p2_nx    = p2_pt_s ? sat_inc(p2_r) : p2_r;
            end else if (elapsed_s) begin
               if (state_r == ST_QUESTION) begin
                  state_nx = ST_INPUT;
                  din_nx   = 4'd0;
               end else if (din_r == DIN_MAX) begin
                  state_nx = ST_DRAW;
               end else begin
                  din_nx = din_r + 4'd1;
               end
            end else begin
               state_nx = state_r;
            end
         end
         ST_DRAW, ST_WRONG, ST_GOOD, ST_OUCH, ST_WIN, ST_LOSE: begin
            if (elapsed_s) begin
               state_nx = ((p1_r == SCORE_MAX) || (p2_r == SCORE_MAX)) ? ST_IDLE : ST_READY;
            end else begin
               state_nx = state_r;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
      if (state_nx != ST_INPUT) begin
         din_nx = 4'd0;
      end else begin
         din_nx = din_nx;
      end
   end

   // Game registers; reset aborts any round in progress.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r <= ST_IDLE;
         que_r   <= 4'd0;
         din_r   <= 4'd0;
         p1_r    <= 4'd0;
         p2_r    <= 4'd0;
      end else begin
         state_r <= state_nx;
         que_r   <= que_nx;
         din_r   <= din_nx;
         p1_r    <= p1_nx;
         p2_r    <= p2_nx;
      end
   end

   // Free-running question generator.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         lfsr_r <= LFSR_SEED;
      end else begin
         lfsr_r <= lfsr_next(lfsr_r);
      end
   end

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Directed bench for game_seq_ctrl with a fast timer configuration.
module tb_game_seq_ctrl;

   localparam logic [3:0] S_IDLE = 4'b0000, S_READY = 4'b0010, S_QUESTION = 4'b0011;
   localparam logic [3:0] S_INPUT = 4'b0100, S_DRAW = 4'b0110, S_WRONG = 4'b0111;
   localparam logic [3:0] S_GOOD = 4'b1000, S_OUCH = 4'b1001, S_WIN = 4'b1010, S_LOSE = 4'b1011;

   logic       CLK, RST, START, P1_ENT, P2_ENT;
   logic [3:0] P1_DIN, P2_DIN, STATE, QUE, DIN, P1_SCORE, P2_SCORE;

   int         vectors = 0;
   int         miscompares = 0;
   logic [3:0] s1 = 4'd0, s2 = 4'd0, eq, ans;
   logic [7:0] m_lfsr, m_prev;

   game_seq_ctrl #(
      .TICK_DIV(4), .READY_TICKS(2), .QUESTION_TICKS(3),
      .INPUT_STEP(1), .RESULT_TICKS(2), .LFSR_SEED(8'hA5)
   ) dut (
      .CLK(CLK), .RST(RST), .START(START),
      .P1_ENT(P1_ENT), .P1_DIN(P1_DIN), .P2_ENT(P2_ENT), .P2_DIN(P2_DIN),
      .STATE(STATE), .QUE(QUE), .DIN(DIN), .P1_SCORE(P1_SCORE), .P2_SCORE(P2_SCORE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference LFSR: x^8+x^6+x^5+x^4+1, m_prev holds the value used at the last edge.
   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         m_lfsr <= 8'hA5;
         m_prev <= 8'hA5;
      end else begin
         m_prev <= m_lfsr;
         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      end
   end

   function automatic logic [3:0] ref_spf(input logic [3:0] q);
      case (q)
         4'd4, 4'd6, 4'd8: return 4'd2;
         4'd9:             return 4'd3;
         default:          return q;
      endcase
   endfunction

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic enter(input logic e1, input logic [3:0] d1, input logic e2, input logic [3:0] d2);
      P1_ENT = e1; P1_DIN = d1; P2_ENT = e2; P2_DIN = d2;
      step(1);
      P1_ENT = 1'b0; P2_ENT = 1'b0;
   endtask

   task automatic check_scores(input string tag);
      check({tag, "_p1"}, P1_SCORE, s1);
      check({tag, "_p2"}, P2_SCORE, s2);
   endtask

   // Called one step after READY entry with 'spent' READY cycles already used.
   task automatic to_question(input int spent);
      step(7 - spent);
      check("ready_hold", STATE, S_READY);
      step(1);
      check("question", STATE, S_QUESTION);
      eq = 4'd2 + {1'b0, m_prev[2:0]};
      check("que", QUE, eq);
      check("que_range", {3'b000, (QUE >= 4'd2) && (QUE <= 4'd9)}, 4'd1);
      ans = ref_spf(eq);
   endtask

   task automatic question_to_input();
      step(11);
      check("question_hold", STATE, S_QUESTION);
      step(1);
      check("input", STATE, S_INPUT);
      check("din_start", DIN, 4'd0);
   endtask

   // Called right after the judging edge; checks the hold and the exit.
   task automatic result(input string tag, input logic [3:0] st);
      check(tag, STATE, st);
      check({tag, "_din"}, DIN, 4'd0);
      check_scores(tag);
      step(7);
      check({tag, "_hold"}, STATE, st);
      step(1);
      check({tag, "_exit"}, STATE, (s1 == 4'd9 || s2 == 4'd9) ? S_IDLE : S_READY);
   endtask

   initial begin
      RST = 1'b1; START = 1'b0; P1_ENT = 1'b0; P2_ENT = 1'b0;
      P1_DIN = 4'd0; P2_DIN = 4'd0;
      step(2);
      RST = 1'b0;
      check("rst_state", STATE, S_IDLE);
      check("rst_que", QUE, 4'd0);
      check("rst_din", DIN, 4'd0);
      check_scores("rst");
      step(3);
      check("idle_hold", STATE, S_IDLE);

      START = 1'b1; step(1); START = 1'b0;
      check("start", STATE, S_READY);

      to_question(0); question_to_input();
      enter(1'b1, ans, 1'b0, 4'd0); s1 = s1 + 4'd1;
      result("p1_win", S_WIN);

      to_question(0); question_to_input();
      enter(1'b0, 4'd0, 1'b1, 4'd9); s1 = s1 + 4'd1;
      result("p2_wrong", S_OUCH);

      to_question(0); question_to_input();
      enter(1'b1, ans, 1'b1, ans);
      result("both_good", S_GOOD);

      to_question(0); question_to_input();
      for (int k = 1; k <= 9; k++) begin
         step(4);
         check("din_step", DIN, 4'(k));
         check("din_state", STATE, S_INPUT);
      end
      step(4);
      result("timeout", S_DRAW);

      to_question(0); question_to_input();
      enter(1'b1, 4'd9, 1'b0, 4'd0); s2 = s2 + 4'd1;
      result("p1_wrong", S_WRONG);

      to_question(0); question_to_input();
      enter(1'b0, 4'd0, 1'b1, ans); s2 = s2 + 4'd1;
      result("p2_win", S_LOSE);

      to_question(0); question_to_input();
      enter(1'b1, ans, 1'b1, 4'd9); s1 = s1 + 4'd1;
      result("p1_ok_p2_bad", S_WIN);

      to_question(0); question_to_input();
      enter(1'b1, 4'd9, 1'b1, 4'd0);
      result("both_wrong", S_DRAW);

      to_question(0); question_to_input();
      enter(1'b1, 4'd9, 1'b1, ans); s2 = s2 + 4'd1;
      result("p1_bad_p2_ok", S_LOSE);

      // Entries and START during READY change nothing.
      P1_ENT = 1'b1; P1_DIN = ans; P2_ENT = 1'b1; P2_DIN = ans; START = 1'b1;
      step(1);
      P1_ENT = 1'b0; P2_ENT = 1'b0; START = 1'b0;
      check("ready_ignore", STATE, S_READY);
      check_scores("ready_ignore");

      // Entry during QUESTION with the right answer.
      to_question(1);
      step(2);
      enter(1'b1, ans, 1'b0, 4'd0);
`ifdef FALSE_START_EN
      s2 = s2 + 4'd1;
      result("false_start", S_WRONG);
`else
      check("fs_ignored", STATE, S_QUESTION);
      check_scores("fs_ignored");
      step(8);
      check("fs_question_hold", STATE, S_QUESTION);
      step(1);
      check("fs_input", STATE, S_INPUT);
      enter(1'b1, ans, 1'b0, 4'd0); s1 = s1 + 4'd1;
      result("fs_later_win", S_WIN);
`endif

      while (s1 < 4'd9) begin
         to_question(0); question_to_input();
         enter(1'b1, ans, 1'b0, 4'd0); s1 = s1 + 4'd1;
         result("win_run", S_WIN);
      end
      step(5);
      check("match_idle", STATE, S_IDLE);
      check_scores("match_idle");

      START = 1'b1; step(1); START = 1'b0;
      s1 = 4'd0; s2 = 4'd0;
      check("restart", STATE, S_READY);
      check_scores("restart");

      to_question(0); question_to_input();
      step(2);
      RST = 1'b1;
      #1;
      check("arst_state", STATE, S_IDLE);
      check("arst_que", QUE, 4'd0);
      check("arst_din", DIN, 4'd0);
      check_scores("arst");
      step(2);
      RST = 1'b0;
      step(2);
      check("arst_idle", STATE, S_IDLE);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
